// File: rtl/dec_scan_pkg.sv
// Shared types and encodings for the dec_scan_seq scan sequencer.
package dec_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DN       = 1'b1;

endpackage

// File: rtl/dec_onehot.sv
// Combinational IN_W-to-2**IN_W one-hot decoder with enable.
// DEC_SCAN_INV_OUT_EN selects an active-low output (inactive = all ones).
module dec_onehot #(
    parameter int IN_W = 3
) (
    input  logic [IN_W-1:0]      sel_i,
    input  logic                 en_i,
    output logic [(2**IN_W)-1:0] out_o
);

    logic [(2**IN_W)-1:0] onehot;

    always_comb begin
        onehot = '0;
        if (en_i) begin
            onehot[sel_i] = 1'b1;
        end
    end

`ifdef DEC_SCAN_INV_OUT_EN
    assign out_o = ~onehot;
`else
    assign out_o = onehot;
`endif

endmodule

// File: rtl/dec_scan_seq.sv
// Auto-stepping one-hot scan sequencer: holds each index DWELL cycles, free-run or one-shot.
// Output polarity is selected by DEC_SCAN_INV_OUT_EN (see dec_onehot).
module dec_scan_seq
    import dec_scan_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 mode,
    input  logic                 dir,
    input  logic                 load,
    input  logic [IN_W-1:0]      load_val,
    output logic [IN_W-1:0]      sel,
    output logic [(2**IN_W)-1:0] out,
    output logic                 busy,
    output logic                 done
);

    localparam int              DW_W    = $clog2(DWELL + 1);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

    state_e          state_q, state_d;
    logic [IN_W-1:0] sel_q, sel_d;
    logic [DW_W-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [IN_W-1:0] term_idx;

    // One-shot ends on the last index in the current sweep direction.
    assign term_idx = (dir == DIR_DN) ? '0 : '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (load) begin
            sel_d = load_val;
            cnt_d = '0;
        end else if (state_q == IDLE) begin
            if (start && en) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else if (en) begin
            if (cnt_q == DW_LAST) begin
                cnt_d = '0;
                if ((mode == MODE_ONESHOT) && (sel_q == term_idx)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (dir == DIR_DN) begin
                    sel_d = sel_q - IN_W'(1);
                end else begin
                    sel_d = sel_q + IN_W'(1);
                end
            end else begin
                cnt_d = cnt_q + DW_W'(1);
            end
        end
    end

    dec_onehot #(
        .IN_W (IN_W)
    ) u_dec (
        .sel_i (sel_q),
        .en_i  (en && (state_q == RUN)),
        .out_o (out)
    );

    assign sel  = sel_q;
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
// Self-checking bench for dec_scan_seq: directed scenarios plus randomized traffic vs a behavioural model.
module tb_dec_scan_seq;

    localparam int IN_W  = 3;
    localparam int DWELL = 2;
    localparam int OUT_W = 2**IN_W;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en, start, stop, mode, dir, load;
    logic [IN_W-1:0] load_val;
    logic [IN_W-1:0] sel;
    logic [OUT_W-1:0] out;
    logic            busy, done;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: running flag, index, cycles spent on current index, done pulse.
    bit m_run  = 1'b0;
    int m_sel  = 0;
    int m_age  = 0;
    bit m_done = 1'b0;

    dec_scan_seq #(.IN_W(IN_W), .DWELL(DWELL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .sel      (sel),
        .out      (out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] pol(input logic [OUT_W-1:0] v);
`ifdef DEC_SCAN_INV_OUT_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0; m_sel = 0; m_age = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (stop) begin
                m_run = 1'b0; m_age = 0;
            end else if (load) begin
                m_sel = int'(load_val); m_age = 0;
            end else if (!m_run) begin
                if (start && en) begin
                    m_run = 1'b1; m_age = 0;
                end
            end else if (en) begin
                m_age++;
                if (m_age == DWELL) begin
                    m_age = 0;
                    if (mode && (m_sel == (dir ? 0 : OUT_W - 1))) begin
                        m_run = 1'b0; m_done = 1'b1;
                    end else begin
                        m_sel = (m_sel + (dir ? OUT_W - 1 : 1)) % OUT_W;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [OUT_W-1:0] exp_out;
        exp_out = (m_run && en) ? OUT_W'(1) << m_sel : '0;
        check("model_sel",  32'(sel),  32'(m_sel));
        check("model_out",  32'(out),  32'(pol(exp_out)));
        check("model_busy", 32'(busy), 32'(m_run));
        check("model_done", 32'(done), 32'(m_done));
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0;
        mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
        #12 rst_n = 1'b1;
        @(negedge clk);
        check("rst_sel",  32'(sel),  32'h0);
        check("rst_out",  32'(out),  32'(pol(8'h00)));
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        tick();

        // Free-run up: each one-hot value held DWELL cycles, wraps 80 -> 01.
        en = 1'b1; mode = 1'b0; dir = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            check("free_out",  32'(out),  32'(pol(8'h01 << ((k / 2) % 8))));
            check("free_busy", 32'(busy), 32'h1);
            tick();
        end

        // Asynchronous reset mid-sweep, observed before the next edge.
        #3 rst_n = 1'b0;
        #1;
        check("async_sel",  32'(sel),  32'h0);
        check("async_out",  32'(out),  32'(pol(8'h00)));
        check("async_busy", 32'(busy), 32'h0);
        check("async_done", 32'(done), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();

        // One-shot down from 3.
        mode = 1'b1; dir = 1'b1; load_val = 3'd3; load = 1'b1;
        tick();
        load = 1'b0;
        @(negedge clk);
        check("os_load_sel", 32'(sel), 32'h3);
        check("os_idle_out", 32'(out), 32'(pol(8'h00)));
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("os_out",  32'(out),  32'(pol(8'h08 >> (k / 2))));
            check("os_done", 32'(done), 32'h0);
            tick();
        end
        @(negedge clk);
        check("os_done_pulse", 32'(done), 32'h1);
        check("os_end_out",    32'(out),  32'(pol(8'h00)));
        check("os_end_busy",   32'(busy), 32'h0);
        tick();
        @(negedge clk);
        check("os_done_clear", 32'(done), 32'h0);
        tick();

        // Enable freeze at sel=5, half-way through its dwell.
        mode = 1'b0; dir = 1'b0; load_val = 3'd5; load = 1'b1;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("frz_pre_out", 32'(out), 32'(pol(8'h20)));
        tick();
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("frz_out",  32'(out),  32'(pol(8'h00)));
            check("frz_sel",  32'(sel),  32'h5);
            check("frz_busy", 32'(busy), 32'h1);
            tick();
        end
        en = 1'b1;
        @(negedge clk);
        check("frz_resume_sel", 32'(sel), 32'h5);
        tick();
        @(negedge clk);
        check("frz_step_sel", 32'(sel), 32'h6);
        check("frz_step_out", 32'(out), 32'(pol(8'h40)));
        tick();

        // Load collides with a dwell step from 6: load wins.
        load_val = 3'd2; load = 1'b1;
        tick();
        load = 1'b0;
        @(negedge clk);
        check("col_sel",  32'(sel),  32'h2);
        check("col_out",  32'(out),  32'(pol(8'h04)));
        check("col_busy", 32'(busy), 32'h1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        @(negedge clk);
        check("stop_busy", 32'(busy), 32'h0);
        check("stop_sel",  32'(sel),  32'h2);
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        @(negedge clk);
        check("stopstart_busy", 32'(busy), 32'h0);
        check("stopstart_out",  32'(out),  32'(pol(8'h00)));
        tick();

        // Randomized traffic; the negedge compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            stop  = (r < 3);
            load  = (r >= 3 && r < 7);
            start = (r >= 7 && r < 25);
            load_val = IN_W'($urandom);
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            if ($urandom_range(0, 19) == 0) dir  = ~dir;
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1; stop = 1'b0; load = 1'b0; start = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
